// File: rtl/adpcm_sched_pkg.sv
// Shared definitions for the adpcm_main run scheduler.
//   state_t            : scheduler FSM states
//   WDOG_LIMIT_DEFAULT : default per-run watchdog limit in cycles
//   idx_w()            : bit width of a requester index
package adpcm_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int WDOG_LIMIT_DEFAULT = 65535;

    // Width needed to hold a requester index 0..n-1 (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adpcm_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req    [NUM_REQ]  request vector
//   i_last   [IDX_W]    index of the previous winner
//   o_winner [IDX_W]    first set request searching upward from i_last+1, wrapping
//   o_any               at least one request is set
module adpcm_rr_pick
    import adpcm_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [idx_w(NUM_REQ)-1:0]  i_last,
    output logic [idx_w(NUM_REQ)-1:0]  o_winner,
    output logic                       o_any
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down to the nearest one so that the
    // closest requester after i_last is the last (and winning) assignment.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adpcm_run_sched.sv
// Run scheduler for one shared adpcm_main HLS core.
// Arbitrates NUM_REQ requesters round-robin, drives the core's ap_ctrl_hs
// start handshake, waits for ap_done and returns a one-cycle one-hot
// completion pulse to the requester that owned the run.
//
// Optional build macro: ADPCM_RUN_SCHED_WDOG_EN enables a per-run watchdog
// that parks the FSM in ERR (sticky timeout_err) after WDOG_LIMIT cycles
// without ap_done. Without the macro timeout_err is tied 0.
//
// Ports:
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   req_valid  [NUM_REQ]      run requests, held until accepted
//   req_ready  [NUM_REQ]      one-hot accept (combinational, IDLE only)
//   done_valid [NUM_REQ]      one-hot completion pulse to the run owner
//   core_ap_start             to core ap_start
//   core_ap_done/idle/ready   from core
//   busy                      FSM not in IDLE
//   owner                     current or last run owner
//   run_count  [CNT_W]        completed runs, wrapping
//   timeout_err               sticky watchdog error
module adpcm_run_sched
    import adpcm_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         done_valid,
    output logic                       core_ap_start,
    input  logic                       core_ap_done,
    input  logic                       core_ap_idle,
    input  logic                       core_ap_ready,
    output logic                       busy,
    output logic [idx_w(NUM_REQ)-1:0]  owner,
    output logic [CNT_W-1:0]           run_count,
    output logic                       timeout_err
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || WDOG_LIMIT < 1) begin : g_param_check
        $error("adpcm_run_sched: parameter out of range");
    end

    state_t             r_state;
    logic               r_start;
    logic [NUM_REQ-1:0] r_done_valid;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_count;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any;
    logic               w_accept;
    logic               w_wdog_hit;

    adpcm_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (req_valid),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_accept  = (r_state == IDLE) && core_ap_idle && w_any;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;

`ifdef ADPCM_RUN_SCHED_WDOG_EN
    logic [31:0] r_wdog;
    logic        r_terr;

    // Counter value k means k cycles have elapsed since entering START, so
    // hitting LIMIT-1 lands the FSM in ERR exactly WDOG_LIMIT cycles in.
    assign w_wdog_hit = (r_wdog == 32'(WDOG_LIMIT - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wdog <= '0;
            r_terr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wdog <= '0;
            end else if (r_state == START || r_state == WAIT) begin
                r_wdog <= r_wdog + 32'd1;
            end
            if ((r_state == START && !(core_ap_ready && core_ap_done) && w_wdog_hit) ||
                (r_state == WAIT  && !core_ap_done && w_wdog_hit)) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_wdog_hit  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state      <= IDLE;
            r_start      <= 1'b0;
            r_done_valid <= '0;
            r_owner      <= '0;
            r_last       <= IDX_W'(NUM_REQ - 1);
            r_count      <= '0;
        end else begin
            r_done_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_winner;
                        r_start <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    // done without ready is a core protocol violation: ignored.
                    if (core_ap_ready && core_ap_done) begin
                        r_start      <= 1'b0;
                        r_done_valid <= NUM_REQ'(1) << r_owner;
                        r_state      <= DONE;
                    end else if (w_wdog_hit) begin
                        r_start <= 1'b0;
                        r_state <= ERR;
                    end else if (core_ap_ready) begin
                        r_start <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_ap_done) begin
                        r_done_valid <= NUM_REQ'(1) << r_owner;
                        r_state      <= DONE;
                    end else if (w_wdog_hit) begin
                        r_state <= ERR;
                    end
                end
                DONE: begin
                    r_count <= r_count + CNT_W'(1);
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                ERR: begin
                    r_start <= 1'b0;
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign core_ap_start = r_start;
    assign done_valid    = r_done_valid;
    assign busy          = (r_state != IDLE);
    assign owner         = r_owner;
    assign run_count     = r_count;

endmodule

// File: tb/tb_adpcm_run_sched.sv
// Directed bench for adpcm_run_sched (NUM_REQ=4, WDOG_LIMIT=20).
module tb_adpcm_run_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  done_valid;
    logic        core_ap_start;
    logic        core_ap_done;
    logic        core_ap_idle;
    logic        core_ap_ready;
    logic        busy;
    logic [1:0]  owner;
    logic [31:0] run_count;
    logic        timeout_err;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cnt [4];
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    adpcm_run_sched #(
        .NUM_REQ    (4),
        .CNT_W      (32),
        .WDOG_LIMIT (20)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .done_valid    (done_valid),
        .core_ap_start (core_ap_start),
        .core_ap_done  (core_ap_done),
        .core_ap_idle  (core_ap_idle),
        .core_ap_ready (core_ap_ready),
        .busy          (busy),
        .owner         (owner),
        .run_count     (run_count),
        .timeout_err   (timeout_err)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        ap_rst = 1'b1; req_valid = '0; core_ap_done = 1'b0;
        core_ap_ready = 1'b0; core_ap_idle = 1'b1;
        step(); step();
        chk("rst_start", core_ap_start, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_count", run_count, 0);
        chk("rst_terr", timeout_err, 0);
        ap_rst = 1'b0;
        step();

        // single run, requester 0, done 5 cycles after ready
        req_valid = 4'b0001; #1;
        chk("t1_accept", req_ready, 4'b0001);
        step();
        req_valid = '0; core_ap_ready = 1'b1; #1;
        chk("t1_start", core_ap_start, 1);
        chk("t1_owner", owner, 0);
        chk("t1_busy", busy, 1);
        step();
        core_ap_ready = 1'b0; #1;
        chk("t1_start_drop", core_ap_start, 0);
        repeat (4) step();
        chk("t1_no_early_done", done_valid, 0);
        core_ap_done = 1'b1;
        step();
        core_ap_done = 1'b0; #1;
        chk("t1_done", done_valid, 4'b0001);
        chk("t1_count_pre", run_count, 0);
        step();
        chk("t1_done_clr", done_valid, 0);
        chk("t1_count", run_count, 1);
        chk("t1_idle", busy, 0);

        // round-robin over 8 runs from a fresh reset
        ap_rst = 1'b1; step(); ap_rst = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_accept", req_ready, 32'(1) << exp_order[k]);
            step();
            #1;
            chk("t2_owner", owner, exp_order[k]);
            core_ap_ready = 1'b1;
            step();
            core_ap_ready = 1'b0; core_ap_done = 1'b1;
            step();
            core_ap_done = 1'b0; #1;
            chk("t2_done", done_valid, 32'(1) << exp_order[k]);
            for (int i = 0; i < 4; i++) if (done_valid[i]) cnt[i]++;
            step();
        end
        req_valid = '0; #1;
        chk("t2_count", run_count, 8);
        for (int i = 0; i < 4; i++) chk("t2_per_req", cnt[i], 2);

        // ap_ready held low 10 cycles, then ready+done together
        req_valid = 4'b0010; #1;
        chk("t3_accept", req_ready, 4'b0010);
        step();
        req_valid = '0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk("t3_start_held", core_ap_start, 1);
            core_ap_done = (i == 5);
            step();
        end
        core_ap_done = 1'b1; core_ap_ready = 1'b1; #1;
        chk("t3_start_last", core_ap_start, 1);
        step();
        core_ap_done = 1'b0; core_ap_ready = 1'b0; #1;
        chk("t3_start_drop", core_ap_start, 0);
        chk("t3_done", done_valid, 4'b0010);
        step();
        chk("t3_done_once", done_valid, 0);
        chk("t3_count", run_count, 9);

        // core not idle blocks acceptance
        core_ap_idle = 1'b0; req_valid = 4'b0100; #1;
        chk("t4_no_accept", req_ready, 0);
        chk("t4_busy", busy, 0);
        step();
        chk("t4_no_accept2", req_ready, 0);
        chk("t4_no_start", core_ap_start, 0);
        core_ap_idle = 1'b1; #1;
        chk("t4_accept", req_ready, 4'b0100);
        step();
        req_valid = '0; core_ap_ready = 1'b1; #1;
        chk("t4_owner", owner, 2);
        chk("t4_start", core_ap_start, 1);
        step();
        core_ap_ready = 1'b0; #1;
        chk("t4_wait_busy", busy, 1);

        // reset in WAIT aborts the run
        ap_rst = 1'b1;
        step();
        chk("t5_start", core_ap_start, 0);
        chk("t5_busy", busy, 0);
        chk("t5_owner", owner, 0);
        chk("t5_count", run_count, 0);
        chk("t5_done", done_valid, 0);
        chk("t5_ready", req_ready, 0);
        ap_rst = 1'b0; core_ap_done = 1'b1;
        step();
        core_ap_done = 1'b0; #1;
        chk("t5_no_done", done_valid, 0);
        chk("t5_count2", run_count, 0);
        req_valid = 4'b0101; #1;
        chk("t5_prio0", req_ready, 4'b0001);
        step();
        req_valid = '0; #1;
        chk("t5_owner0", owner, 0);
        core_ap_ready = 1'b1; core_ap_done = 1'b1;
        step();
        core_ap_ready = 1'b0; core_ap_done = 1'b0; #1;
        chk("t5_done0", done_valid, 4'b0001);
        step();
        chk("t5_count1", run_count, 1);

`ifdef ADPCM_RUN_SCHED_WDOG_EN
        // watchdog: core never signals done
        req_valid = 4'b0001; #1;
        chk("t6_accept", req_ready, 4'b0001);
        step();
        req_valid = '0; core_ap_ready = 1'b1;
        for (int i = 1; i < 20; i++) begin
            step();
            core_ap_ready = 1'b0;
        end
        #1;
        chk("t6_terr_pre", timeout_err, 0);
        chk("t6_busy_pre", busy, 1);
        req_valid = 4'b1111;
        step();
        chk("t6_terr", timeout_err, 1);
        chk("t6_busy", busy, 1);
        chk("t6_start", core_ap_start, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_done", done_valid, 0);
        repeat (3) step();
        chk("t6_terr_sticky", timeout_err, 1);
        chk("t6_ready_sticky", req_ready, 0);
        ap_rst = 1'b1; req_valid = '0;
        step();
        ap_rst = 1'b0; #1;
        chk("t6_terr_clr", timeout_err, 0);
        chk("t6_busy_clr", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
